two_slot_break_dvr_r: RTL and testbench
=======================================

// Module: two_slot_break_dvr_r
// PURPOSE
//  Two-entry elastic stage that registers data, valid AND ready: no combinational path in->out in either direction.
//  Sits directly upstream of one_slot_break_dvr stages on long handshake chains; that stage cuts data/valid only,
//  so this block also cuts the backward ready path the downstream buffer leaves combinational.
//  Full throughput (1 transfer/cycle), 1-cycle latency, strict FIFO ordering.
// PARAMETERS
//  DATA_TYPE   32   data width in bits (>= 1)
// PORTS
//  clk         in   1          clock, all state updates on posedge
//  rst         in   1          reset: synchronous, active-high
//  ins         in   DATA_TYPE  input data
//  ins_valid   in   1          input valid
//  ins_ready   out  1          input ready; driven directly by a flop
//  outs        out  DATA_TYPE  output data; driven directly by the main data register
//  outs_valid  out  1          output valid; driven directly by a flop
//  outs_ready  in   1          output ready
// BEHAVIOUR
//  Storage: main reg (drives outs) + skid reg. Transfer in = ins_valid & ins_ready; out = outs_valid & outs_ready.
//  States (2-bit encoded, one-hot allowed): EMPTY (0 held), ONE (main full), TWO (main+skid full).
//  Registered outputs per state: EMPTY ins_ready=1 outs_valid=0; ONE ins_ready=1 outs_valid=1; TWO ins_ready=0 outs_valid=1.
//  Transitions (next state sets next-cycle ins_ready/outs_valid flops):
//   EMPTY: in -> main<=ins, ONE.  no in -> stay.
//   ONE:   in & out -> main<=ins, stay ONE.  in only -> skid<=ins, TWO.  out only -> EMPTY.  neither -> stay.
//   TWO:   out -> main<=skid, ONE.  no out -> stay.  ins/ins_valid ignored (ins_ready=0).
//  Latency: word accepted at edge k is on outs with outs_valid=1 from edge k through cycle after; i.e. visible 1 cycle later.
//  Stability: while outs_valid=1 & outs_ready=0, outs and outs_valid hold unchanged (AXI-style no-retract).
//  Ordering: main always holds the older word; skid never bypasses main.
//  Data regs load only on the enables above; otherwise hold. No combinational use of outs_ready or ins_valid
//   in driving any output port.
//  Reset (rst=1 at posedge): state<=EMPTY, outs_valid<=0, ins_ready<=1, main<=0, skid<=0.
//   Reset mid-operation discards both held words; no transfer is reported on the reset edge; first accept
//   possible on the first edge with rst=0.
//  ins_valid may drop without a transfer (upstream non-compliance tolerated, nothing captured).
//  Width: no arithmetic; all data paths exactly DATA_TYPE bits, no truncation/extension.
// TESTING
//  1 Reset: hold rst 2 cycles with ins_valid=1 ins=0xAA -> after release outs_valid=0, ins_ready=1, outs=0, nothing captured.
//  2 Streaming: ins 1,2,3,...,100 valid every cycle, outs_ready=1 -> outs 1..100 in order, 1 cycle late, ins_ready never 0.
//  3 Fill/backpressure: outs_ready=0, send 0x11,0x22,0x33 -> 0x11,0x22 accepted, ins_ready=0 from cycle after 0x22,
//    outs=0x11 stable; raise outs_ready -> 0x11,0x22,0x33 delivered in order, no loss/duplication.
//  4 Simultaneous in/out in ONE: hold 0x5 in main, same edge ins=0x6 valid & outs_ready=1 -> outs=0x6 next cycle, state ONE.
//  5 Random: random ins_valid/outs_ready (>=10k cycles, 50% each) vs scoreboard -> order preserved, outs stable under stall,
//    no output port changes except on clk edge, occupancy never >2.
//  6 Reset in TWO: fill 0xA,0xB, assert rst one cycle -> outs_valid=0, ins_ready=1, 0xA/0xB never appear on outs.

Source files
------------

// File: rtl/two_slot_break_dvr_r.sv
// Two-entry elastic stage with fully registered data, valid and ready.
// The main register drives the output; the skid register catches the one
// word that arrives while the output is stalled. No output port depends
// combinationally on any input port.
module two_slot_break_dvr_r #(
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic                 r_insReady;
    logic                 r_outsValid;
    logic [DATA_TYPE-1:0] r_main;
    logic [DATA_TYPE-1:0] r_skid;

    logic w_inFire;
    logic w_outFire;
    logic w_loadMainIns;
    logic w_loadMainSkid;
    logic w_loadSkid;

    // Handshakes use only the registered ready/valid, so fire terms never
    // create a path from an input port to an output port.
    assign w_inFire  = ins_valid & r_insReady;
    assign w_outFire = r_outsValid & outs_ready;

    // Next-state and data-register load enables from current occupancy and the two handshakes.
    always_comb begin
        w_nextState    = r_state;
        w_loadMainIns  = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_inFire) begin
                    w_loadMainIns = 1'b1;
                    w_nextState   = ONE;
                end
            end
            ONE: begin
                if (w_inFire && w_outFire) begin
                    w_loadMainIns = 1'b1;
                end else if (w_inFire) begin
                    w_loadSkid  = 1'b1;
                    w_nextState = TWO;
                end else if (w_outFire) begin
                    w_nextState = EMPTY;
                end
            end
            TWO: begin
                if (w_outFire) begin
                    w_loadMainSkid = 1'b1;
                    w_nextState    = ONE;
                end
            end
            default: begin
                w_nextState = EMPTY;
            end
        endcase
    end

    // State register plus ready/valid flops, which are precomputed from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_insReady  <= 1'b1;
            r_outsValid <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_insReady  <= (w_nextState != TWO);
            r_outsValid <= (w_nextState != EMPTY);
        end
    end

    // Data registers: main always holds the older word, skid refills main when it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_loadMainIns) begin
                r_main <= ins;
            end else if (w_loadMainSkid) begin
                r_main <= r_skid;
            end
            if (w_loadSkid) begin
                r_skid <= ins;
            end
        end
    end

    assign ins_ready  = r_insReady;
    assign outs_valid = r_outsValid;
    assign outs       = r_main;

endmodule

// File: tb/tb_two_slot_break_dvr_r.sv
// Scoreboard bench for two_slot_break_dvr_r: accepted words are queued on
// the input side and popped by an independent monitor when outs transfers.
module tb_two_slot_break_dvr_r;

    logic        clk;
    logic        rst;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] outs;
    logic        outs_valid;
    logic        outs_ready;

    int total = 0;
    int bad   = 0;

    logic [31:0] sbQ[$];
    int          occupancy = 0;
    bit          monitorOn = 0;

    logic        prevStall = 0;
    logic [31:0] prevOuts  = '0;
    logic [31:0] snapOuts;
    logic        snapValid;
    logic        snapReady;

    two_slot_break_dvr_r #(.DATA_TYPE(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison; prints a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs right after an edge, then wait for the next edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d, input logic rdy);
        rst        = r;
        ins_valid  = v;
        ins        = d;
        outs_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of capacity two. Accepted words go into the
    // scoreboard; occupancy decides what ready/valid must look like.
    always @(posedge clk) begin
        if (rst) begin
            occupancy = 0;
            sbQ.delete();
        end else begin
            if (ins_valid && occupancy < 2) begin
                sbQ.push_back(ins);
                occupancy = occupancy + 1;
                if (outs_ready && occupancy > 1) occupancy = occupancy - 1;
            end else if (outs_ready && occupancy > 0) begin
                occupancy = occupancy - 1;
            end
        end
        monitorOn = 1;
    end

    // Snapshot outputs shortly after each edge (after inputs have been redriven).
    always @(posedge clk) begin
        #2;
        snapOuts  = outs;
        snapValid = outs_valid;
        snapReady = ins_ready;
    end

    // Monitor: away from the active edge, check handshake flags against the
    // model, pop the scoreboard on each output transfer, and check stability.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("ins_ready", {31'd0, ins_ready}, {31'd0, occupancy < 2});
            checkOutput("outs_valid", {31'd0, outs_valid}, {31'd0, occupancy > 0});
            checkOutput("outs_between_edges", outs, snapOuts);
            checkOutput("flags_between_edges", {30'd0, outs_valid, ins_ready}, {30'd0, snapValid, snapReady});
            if (prevStall) begin
                checkOutput("stall_outs_hold", outs, prevOuts);
                checkOutput("stall_valid_hold", {31'd0, outs_valid}, 32'd1);
            end
            if (outs_valid && outs_ready && !rst) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_output", outs, 32'hDEAD_BEEF);
                end else begin
                    checkOutput("outs_data", outs, sbQ.pop_front());
                end
            end
            prevStall = outs_valid && !outs_ready && !rst;
            prevOuts  = outs;
        end
    end

    initial begin
        rst        = 1'b1;
        ins_valid  = 1'b1;
        ins        = 32'hAA;
        outs_ready = 1'b0;

        // Reset held two cycles with a valid word on the input: nothing captured.
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 32'hAA, 1'b0);
        checkOutput("reset_outs", outs, 32'd0);
        checkOutput("reset_outs_valid", {31'd0, outs_valid}, 32'd0);
        checkOutput("reset_ins_ready", {31'd0, ins_ready}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        // Streaming 1..100 with the sink always ready.
        for (int i = 1; i <= 100; i++) applyStimulus(1'b0, 1'b1, i, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Fill under backpressure, then drain.
        applyStimulus(1'b0, 1'b1, 32'h11, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h22, 1'b0);
        checkOutput("fill_ins_ready_low", {31'd0, ins_ready}, 32'd0);
        checkOutput("fill_outs_head", outs, 32'h11);
        applyStimulus(1'b0, 1'b1, 32'h33, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h33, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h33, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Simultaneous in/out while holding one word.
        applyStimulus(1'b0, 1'b1, 32'h5, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h6, 1'b1);
        checkOutput("simul_outs", outs, 32'h6);
        checkOutput("simul_valid", {31'd0, outs_valid}, 32'd1);
        checkOutput("simul_ready", {31'd0, ins_ready}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset while both slots are full: held words discarded.
        applyStimulus(1'b0, 1'b1, 32'hA, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hB, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rst_two_valid", {31'd0, outs_valid}, 32'd0);
        checkOutput("rst_two_ready", {31'd0, ins_ready}, 32'd1);
        checkOutput("rst_two_outs", outs, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic, 50% valid and 50% ready.
        for (int i = 0; i < 12000; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end

        // Drain anything still held and confirm the scoreboard emptied.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("final_scoreboard_empty", sbQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
